// File: rtl/ht_requant_pipe.sv
// ht_requant_pipe: two-stage multi-lane requantizer from int32 accumulators to saturated unsigned Ht codes,
// run as counted bursts under a start/done FSM with per-burst saturation counting.
module ht_requant_pipe #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int DATA_W = 8,
  parameter int CNT_W = 10,
  parameter int SCALE_W_LOG2 = 7,
  parameter int SCALE_DATA_LOG2 = 7,
  parameter int SCALE_B_LOG2 = 8,
  parameter int ZERO_DATA = 128,
  parameter int ZERO_B = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          beats,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               sat_cnt,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_W-1:0]    in_acc,
  input  logic [LANES*8-1:0]        in_bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_ht,
  output logic                      out_last
);
  localparam int SW = ACC_W + 2;
  localparam int NW = $clog2(LANES + 1);
  localparam logic signed [SW-1:0] RW = SW'(2 ** SCALE_W_LOG2 - 1);
  localparam logic signed [SW-1:0] RB = SW'(2 ** SCALE_B_LOG2 - 1);
  localparam logic signed [SW-1:0] ZD = SW'(ZERO_DATA);
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** DATA_W - 1);
  localparam logic signed [9:0] ZB = 10'(ZERO_B);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic s1_valid, adv, in_fire, out_fire;
  logic [LANES-1:0][SW-1:0] s1, s1_next;
  logic [LANES-1:0] sat;
  logic [LANES*DATA_W-1:0] ht_next;
  logic [NW-1:0] nsat, nsat_next;
  logic [16:0] sat_sum;

  assign adv = !out_valid || out_ready;
  assign in_ready = state == S_RUN && in_cnt != '0 && adv;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_last = out_valid && out_cnt == CNT_W'(1);
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign sat_sum = {1'b0, sat_cnt} + 17'(nsat);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [SW-1:0] acc, a, bs, b, sv;
    logic signed [9:0] bd;
    // Negative operands are biased by 2^k-1 so the arithmetic shift truncates toward zero
    assign acc = SW'($signed(in_acc[l*ACC_W +: ACC_W]));
    assign a = acc < 0 ? (acc + RW) >>> SCALE_W_LOG2 : acc >>> SCALE_W_LOG2;
    assign bd = $signed({2'b00, in_bias[l*8 +: 8]}) - ZB;
    assign bs = SW'(bd) <<< SCALE_DATA_LOG2;
    assign b = bs < 0 ? (bs + RB) >>> SCALE_B_LOG2 : bs >>> SCALE_B_LOG2;
    assign s1_next[l] = a + b;
    assign sv = $signed(s1[l]) + ZD;
    assign sat[l] = sv < 0 || sv > MAXV;
    assign ht_next[l*DATA_W +: DATA_W] = sv < 0 ? '0 : sv > MAXV ? '1 : sv[DATA_W-1:0];
  end

  always_comb begin
    nsat_next = '0;
    for (int i = 0; i < LANES; i++) nsat_next = nsat_next + NW'(sat[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      sat_cnt <= '0;
      s1_valid <= 1'b0;
      s1 <= '0;
      out_valid <= 1'b0;
      out_ht <= '0;
      nsat <= '0;
    end else begin
      if (adv) begin
        s1_valid <= in_fire;
        s1 <= s1_next;
        out_valid <= s1_valid;
        out_ht <= ht_next;
        nsat <= nsat_next;
      end
      if (in_fire) in_cnt <= in_cnt - 1'b1;
      if (out_fire) begin
        out_cnt <= out_cnt - 1'b1;
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
      if (state == S_IDLE && start) begin
        state <= beats != '0 ? S_RUN : S_DONE;
        in_cnt <= beats;
        out_cnt <= beats;
        sat_cnt <= '0;
      end else if (state == S_RUN && out_fire && out_last) state <= S_DONE;
      else if (state == S_DONE) state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_ht_requant_pipe.sv
// tb_ht_requant_pipe: directed bursts checked against an arithmetic requantization model and a beat scoreboard.
module tb_ht_requant_pipe;
  localparam int LANES = 4, ACC_W = 32, DATA_W = 8, CNT_W = 10;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [CNT_W-1:0] beats = '0;
  logic busy, done, in_ready, out_valid, out_last;
  logic [15:0] sat_cnt;
  logic [LANES*ACC_W-1:0] in_acc = '0;
  logic [LANES*8-1:0] in_bias = '0;
  logic [LANES*DATA_W-1:0] out_ht;
  int checks = 0, errors = 0;

  ht_requant_pipe dut (
    .clk(clk), .reset(reset), .start(start), .beats(beats), .busy(busy), .done(done),
    .sat_cnt(sat_cnt), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_bias(in_bias), .out_valid(out_valid), .out_ready(out_ready), .out_ht(out_ht),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unclamped requantized value: integer division truncates toward zero
  function automatic longint lane_raw(longint acc, int bias);
    return acc / 128 + (longint'(bias) * 128) / 256 + 128;
  endfunction

  logic [LANES*DATA_W-1:0] exp_q[$];
  int exp_ns_q[$];
  logic [LANES*DATA_W-1:0] got_ht[0:15];
  logic [LANES*DATA_W-1:0] prev_ht;
  logic [LANES*ACC_W-1:0] stim_acc[0:15];
  logic [LANES*8-1:0] stim_bias[0:15];
  int burst_beats = 0, acc_cnt = 0, out_idx = 0, exp_sat = 0;
  bit prev_stall = 0, prev_last_hs = 0;

  always @(negedge clk) if (!reset) begin
    chk("sat_cnt", sat_cnt, exp_sat);
    if (prev_last_hs) chk("done_after_last", done, 1);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_ht, prev_ht);
    end
    if (busy && acc_cnt == burst_beats) chk("in_ready_exhausted", in_ready, 0);
    if (in_valid && in_ready) begin
      logic [LANES*DATA_W-1:0] v;
      int ns;
      ns = 0;
      for (int l = 0; l < LANES; l++) begin
        longint r;
        r = lane_raw(longint'($signed(in_acc[l*ACC_W +: ACC_W])), int'(in_bias[l*8 +: 8]));
        v[l*DATA_W +: DATA_W] = r < 0 ? 8'd0 : r > 255 ? 8'd255 : 8'(r);
        if (r < 0 || r > 255) ns++;
      end
      exp_q.push_back(v);
      exp_ns_q.push_back(ns);
      acc_cnt++;
    end
    if (out_valid) chk("out_last", out_last, out_idx == burst_beats - 1);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        chk("out_ht", out_ht, exp_q.pop_front());
        exp_sat = exp_sat + exp_ns_q.pop_front();
        if (exp_sat > 65535) exp_sat = 65535;
        got_ht[out_idx[3:0]] = out_ht;
        out_idx++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_ht = out_ht;
    prev_last_hs = out_valid && out_ready && out_last;
  end

  task automatic burst(int n, bit rnd, bit tog, bit poke, bit abort);
    int i, cyc;
    bit f;
    @(posedge clk); #1;
    beats = CNT_W'(n);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_q.delete();
    exp_ns_q.delete();
    exp_sat = 0;
    burst_beats = n;
    acc_cnt = 0;
    out_idx = 0;
    i = 0;
    cyc = 0;
    while (!done && cyc < 500) begin
      if (abort && out_idx >= 3) begin
        reset = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sat_cnt", sat_cnt, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        exp_ns_q.delete();
        exp_sat = 0;
        burst_beats = 0;
        acc_cnt = 0;
        prev_stall = 0;
        prev_last_hs = 0;
        in_valid = 0;
        start = 0;
        @(posedge clk); #1;
        reset = 0;
        return;
      end
      in_valid = i < n && (!rnd || $urandom_range(0, 1) == 1);
      in_acc = stim_acc[i];
      in_bias = stim_bias[i];
      out_ready = !tog || cyc % 2 == 1;
      start = poke && cyc == 3;
      if (poke && cyc == 3) beats = 3;
      @(negedge clk);
      f = in_valid && in_ready;
      @(posedge clk); #1;
      if (f) i++;
      cyc++;
    end
    in_valid = 0;
    start = 0;
    chk("done_seen", done, 1);
    chk("beats_out", out_idx, n);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      stim_acc[k] = '0;
      stim_bias[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_ht", out_ht, 0);
    reset = 0;
    // zero-beat burst: straight to DONE, no data; in_valid while idle is refused
    @(posedge clk); #1;
    beats = 0;
    start = 1;
    in_valid = 1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 0;
    in_valid = 0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_out_valid", out_valid, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_out_valid2", out_valid, 0);
    stim_acc[0] = {32'd0, 32'd0, 32'd0, 32'd12800};
    burst(1, 0, 0, 0, 0);
    chk("t1_ht", got_ht[0], 32'h808080E4);
    stim_acc[0] = {32'd0, 32'd127, 32'(-129), 32'(-12800)};
    burst(1, 0, 0, 0, 0);
    chk("t2_ht", got_ht[0], 32'h80807F1C);
    stim_acc[0] = {32'd0, 32'(-50000), 32'd100000, 32'd0};
    stim_bias[0] = {8'd0, 8'd0, 8'd0, 8'd200};
    burst(1, 0, 0, 0, 0);
    chk("t3_ht", got_ht[0], 32'h8000FFE4);
    @(negedge clk);
    chk("t3_sat_cnt", sat_cnt, 2);
    for (int k = 0; k < 16; k++)
      for (int l = 0; l < LANES; l++) begin
        stim_acc[k][l*ACC_W +: ACC_W] = 32'($urandom_range(0, 40000)) - 32'd20000;
        stim_bias[k][l*8 +: 8] = 8'($urandom_range(0, 255));
      end
    burst(8, 1, 1, 0, 0);
    burst(4, 1, 0, 1, 0);
    burst(8, 1, 1, 0, 1);
    burst(4, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
